// File: rtl/send_arbiter_if.sv
// send_arbiter_if: send-queue request bundle and post office output bundle.
interface send_arbiter_if #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W = $clog2(NUM_SOURCES)
);
    logic [NUM_SOURCES-1:0]             send_queue_arbiter_valid;
    logic [NUM_SOURCES-1:0]             arbiter_send_queue_ready;
    logic [NUM_SOURCES-1:0][DATA_W-1:0] send_queue_arbiter_data;
    logic                               arbiter_postoffice_valid;
    logic                               postoffice_arbiter_ready;
    logic [DATA_W-1:0]                  arbiter_postoffice_data;
    logic [SRC_W-1:0]                   arbiter_postoffice_source;
    modport master (
        input  send_queue_arbiter_valid, send_queue_arbiter_data, postoffice_arbiter_ready,
        output arbiter_send_queue_ready, arbiter_postoffice_valid, arbiter_postoffice_data,
               arbiter_postoffice_source
    );
    modport slave (
        output send_queue_arbiter_valid, send_queue_arbiter_data, postoffice_arbiter_ready,
        input  arbiter_send_queue_ready, arbiter_postoffice_valid, arbiter_postoffice_data,
               arbiter_postoffice_source
    );
endinterface

// File: rtl/send_arbiter.sv
// send_arbiter: round-robin share of the post office send port with a one-message output slot.
module send_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    input logic flush,
    send_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(NUM_SOURCES);
    logic              full_q;
    logic [DATA_W-1:0] data_q;
    logic [SRC_W-1:0]  src_q, ptr_q, ptr_d, w, cand;
    logic              any_v, slot_free, xfer;
    // Scan from the highest rotated offset down so the lowest offset wins last.
    always_comb begin
        w = '0;
        any_v = 1'b0;
        cand = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            cand = SRC_W'((int'(ptr_q) + k) % NUM_SOURCES);
            if (bus.send_queue_arbiter_valid[cand]) begin
                w = cand;
                any_v = 1'b1;
            end
        end
    end
    assign slot_free = !full_q || bus.postoffice_arbiter_ready;
    assign xfer = any_v && slot_free && !flush && !rst;
    assign ptr_d = (w == SRC_W'(NUM_SOURCES - 1)) ? '0 : w + 1'b1;
    assign bus.arbiter_send_queue_ready = xfer ? (NUM_SOURCES'(1) << w) : '0;
    assign bus.arbiter_postoffice_valid = full_q;
    assign bus.arbiter_postoffice_data = data_q;
    assign bus.arbiter_postoffice_source = src_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            src_q <= '0;
            ptr_q <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
            ptr_q <= '0;
        end else if (xfer) begin
            full_q <= 1'b1;
            data_q <= bus.send_queue_arbiter_data[w];
            src_q <= w;
            ptr_q <= ptr_d;
        end else if (bus.postoffice_arbiter_ready) begin
            full_q <= 1'b0;
        end
    end
endmodule

// File: doc/send_arbiter.md
Name: send_arbiter

Overview:
- Round-robin arbiter that shares the post office send port between NUM_SOURCES independent send queues (e.g. one per hardware context).
- Sits between the send queues' postoffice-side valid/ready/data outputs and the post office input.
- Holds one registered output slot, so throughput is one message per cycle with 1-cycle latency.
- Tags each message with the index of the source that issued it.

Parameters:
- NUM_SOURCES, 4, number of requesting send queues; must be ≥2.
- SRC_W, $clog2(NUM_SOURCES), width of the source index (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards in-flight state.
- send_queue_arbiter_valid  in  NUM_SOURCES  per-source valid.
- arbiter_send_queue_ready  out  NUM_SOURCES  per-source ready (one-hot or zero).
- send_queue_arbiter_data  in  NUM_SOURCES x send_queue_data_t  per-source payload, packed array indexed by source.
- arbiter_postoffice_valid  out  1  output slot holds a message.
- postoffice_arbiter_ready  in  1  post office accepts.
- arbiter_postoffice_data  out  send_queue_data_t  message payload.
- arbiter_postoffice_source  out  SRC_W  index of the originating source.

Behaviour:
- Reset (async, rst=1) clears all state:
  - arbiter_postoffice_valid=0, data=0, source=0.
  - Priority pointer ptr=0.
  - arbiter_send_queue_ready=0 while rst is high.
- State is the output slot (EMPTY / FULL) plus ptr.
- Slot is free this cycle when: EMPTY, or (FULL and postoffice_arbiter_ready=1). Drain and refill in the same cycle are allowed.
- Arbitration (combinational):
  - Winner w = first i with valid[i]=1, scanning ptr, ptr+1, …, NUM_SOURCES-1, 0, …, ptr-1.
  - ready[w]=1 only if the slot is free and flush=0. All other ready bits are 0.
  - No ready is asserted without a matching valid.
- Transfer on the rising edge when valid[w] & ready[w]:
  - Slot captures data[w] and source=w; slot becomes FULL.
  - ptr ← (w+1) mod NUM_SOURCES. Wrap: w=NUM_SOURCES-1 gives ptr=0.
  - ptr is unchanged on cycles with no transfer.
- Drain without refill: slot becomes EMPTY (valid=0). data and source hold their last values (don't-care).
- Output stability: while valid=1 and ready=0, data and source remain constant.
- Latency: a source transfer in cycle N is presented at the output in cycle N+1.
- Fairness: with all sources continuously valid and the post office always ready, grants are strictly i, i+1, …. Each source waits at most NUM_SOURCES-1 grants.
- Flush=1:
  - All ready=0.
  - At the edge, slot ← EMPTY and ptr ← 0, regardless of postoffice_arbiter_ready. A message draining in that cycle is still considered consumed by the post office.
  - Flush has priority over transfer.
- Backpressure: while the slot is FULL and postoffice_arbiter_ready=0, all readies are 0 and ptr is frozen.
- Source valid may drop without a transfer; the arbiter holds no per-source state, so no lock is required.

Test Plan:
- Reset mid-traffic:
  - Stimulus: assert rst while slot FULL with source=2.
  - Required: arbiter_postoffice_valid=0, source=0, ptr=0 immediately, without waiting for a clock edge.
  - After release, source 0 is granted first when all are valid.
- Round-robin with all valid:
  - Stimulus: valid=4'b1111, post office always ready, data[i]=0x10+i.
  - Required: output sequence 0x10, 0x11, 0x12, 0x13, 0x10… with source 0, 1, 2, 3, 0. First output appears one cycle after the first ready.
- Skip and wrap:
  - Stimulus: ptr=3, valid=4'b0101.
  - Required: grant source 0, then ptr=1, then grant source 2, then ptr=3.
- Backpressure:
  - Stimulus: slot FULL with source 1, ready=0 for 3 cycles.
  - Required: all source readies 0; data and source stable.
  - On the cycle ready returns, the next winner's ready=1 and it is captured in the same cycle (no bubble).
- Flush:
  - Stimulus: flush while slot FULL and valid=4'b1111.
  - Required: no ready asserted that cycle; next cycle output valid=0 and ptr=0; source 0 is granted on the following cycle.
- Single source burst:
  - Stimulus: only valid[3]=1 for 5 messages, ready always 1.
  - Required: 5 back-to-back outputs with source=3, ptr=0 after each.
